// File: rtl/wb_stream_bridge_device_if.sv
// Wishbone classic device port plus TX/RX valid/ready streams.
// Ports: cyc/stb/we/dat_i/ack/err/rty/dat_o bus; tx_*/rx_* streams.
interface wb_stream_bridge_device_if #(
  parameter int DAT_WIDTH = 8
);
  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [DAT_WIDTH-1:0] dat_i;
  logic                 ack_o;
  logic                 err_o;
  logic                 rty_o;
  logic [DAT_WIDTH-1:0] dat_o;
  logic [DAT_WIDTH-1:0] tx_data_o;
  logic                 tx_valid_o;
  logic                 tx_ready_i;
  logic [DAT_WIDTH-1:0] rx_data_i;
  logic                 rx_valid_i;
  logic                 rx_ready_o;

  modport master (
    output cyc_i, stb_i, we_i, dat_i,
    output tx_ready_i, rx_data_i, rx_valid_i,
    input  ack_o, err_o, rty_o, dat_o,
    input  tx_data_o, tx_valid_o, rx_ready_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, dat_i,
    input  tx_ready_i, rx_data_i, rx_valid_i,
    output ack_o, err_o, rty_o, dat_o,
    output tx_data_o, tx_valid_o, rx_ready_o
  );
endinterface

// File: rtl/wb_stream_bridge_device.sv
// Wishbone classic mailbox: writes feed TX FIFO, reads drain RX FIFO.
// Ports: clk_i, rst_ni (async low), bus (slave modport of the _if).
module wb_stream_bridge_device #(
  parameter int DAT_WIDTH      = 8,
  parameter int DEPTH          = 4,
  parameter int WAIT_STATES    = 0,
  parameter int EMPTY_READ_ERR = 0
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  wb_stream_bridge_device_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic ack_q, ack_d;
  logic err_q, err_d;
  logic rty_q, rty_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;

  logic [DAT_WIDTH-1:0] tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d;
  logic [AW-1:0] tx_rp_q, tx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;

  logic [DAT_WIDTH-1:0] rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_wp_d;
  logic [AW-1:0] rx_rp_q, rx_rp_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;

  logic req;
  logic decide;
  logic tx_full, tx_empty;
  logic rx_full, rx_empty;
  logic tx_push, tx_pop;
  logic rx_push, rx_pop;

  assign req      = bus.cyc_i && bus.stb_i;
  assign tx_full  = tx_cnt_q == CW'(DEPTH);
  assign tx_empty = tx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == CW'(DEPTH);
  assign rx_empty = rx_cnt_q == '0;

  // Stream side uses pre-edge occupancy, like the bus side.
  assign tx_pop  = !tx_empty && bus.tx_ready_i;
  assign rx_push = bus.rx_valid_i && !rx_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    decide  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            decide  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!bus.cyc_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          decide  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    dat_d   = dat_q;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    if (decide) begin
      if (bus.we_i) begin
        if (!tx_full) begin
          tx_push = 1'b1;
          ack_d   = 1'b1;
        end else begin
          rty_d = 1'b1;
        end
      end else if (!rx_empty) begin
        rx_pop = 1'b1;
        ack_d  = 1'b1;
        dat_d  = rx_mem_q[rx_rp_q];
      end else if (EMPTY_READ_ERR != 0) begin
        err_d = 1'b1;
      end else begin
        rty_d = 1'b1;
      end
    end
  end

  always_comb begin
    tx_wp_d  = tx_wp_q + AW'(tx_push);
    tx_rp_d  = tx_rp_q + AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push)
             - CW'(tx_pop);
    rx_wp_d  = rx_wp_q + AW'(rx_push);
    rx_rp_d  = rx_rp_q + AW'(rx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push)
             - CW'(rx_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
      dat_q    <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      rty_q    <= rty_d;
      dat_q    <= dat_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      if (tx_push) tx_mem_q[tx_wp_q] <= bus.dat_i;
      if (rx_push) rx_mem_q[rx_wp_q] <= bus.rx_data_i;
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.err_o      = err_q;
  assign bus.rty_o      = rty_q;
  assign bus.dat_o      = dat_q;
  assign bus.tx_valid_o = !tx_empty;
  assign bus.tx_data_o  = tx_empty ? '0
                        : tx_mem_q[tx_rp_q];
  assign bus.rx_ready_o = !rx_full;

endmodule
